// File: rtl/imem_loader_if.sv
// Byte-stream receive and instruction-memory write bundle for imem_loader.
// slave = loader side, master = byte source / memory / CPU side.
interface imem_loader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8
);
    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [DATA_WIDTH-1:0] imem_wdata;
    logic                  cpu_hold;
    logic                  done;
    logic                  error;

    modport slave (
        input  rx_valid, rx_data,
        output rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );

    modport master (
        output rx_valid, rx_data,
        input  rx_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader for instruction memory; holds the CPU in reset until an image lands.
// Optional trailing checksum byte is compiled in with IMEM_LOADER_CSUM_EN.
module imem_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int IMEM_DEPTH = 256,
    parameter int ADDR_WIDTH = $clog2(IMEM_DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);

    localparam logic [7:0] SYNC  = 8'hA5;
    localparam logic [9:0] DEPTH = 10'(IMEM_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_COUNT, S_HI, S_LO, S_CSUM, S_DONE, S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [8:0]            cnt_q, cnt_d;
    logic [8:0]            idx_q, idx_d;
    logic [7:0]            hi_q, hi_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  hold_q, hold_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;

    logic       fire;
    logic [8:0] cnt_rx;
    logic [8:0] idx_inc;

`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0] sum_q, sum_d;
    logic [7:0] sum_nxt;
    assign sum_nxt = sum_q + bus.rx_data;
`endif

    // The only stall is the dead cycle while a write strobe is out.
    assign bus.rx_ready = ~we_q;
    assign fire         = bus.rx_valid & ~we_q;
    assign cnt_rx       = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
    assign idx_inc      = idx_q + 9'd1;

    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.cpu_hold   = hold_q;
    assign bus.done       = done_q;
    assign bus.error      = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            hi_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
            sum_q   <= sum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
`ifdef IMEM_LOADER_CSUM_EN
        sum_d   = sum_q;
`endif
        if (fire) begin
            case (state_q)
                // Outside a frame only the sync byte matters; it also re-arms the hold.
                S_IDLE, S_DONE, S_ERR: begin
                    if (bus.rx_data == SYNC) begin
                        state_d = S_COUNT;
                        hold_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
                        sum_d   = '0;
`endif
                    end
                end
                S_COUNT: begin
                    cnt_d = cnt_rx;
                    if ({1'b0, cnt_rx} > DEPTH) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end else begin
                        idx_d   = '0;
                        state_d = S_HI;
                    end
                end
                S_HI: begin
                    hi_d    = bus.rx_data;
                    state_d = S_LO;
`ifdef IMEM_LOADER_CSUM_EN
                    sum_d   = sum_nxt;
`endif
                end
                S_LO: begin
                    we_d    = 1'b1;
                    addr_d  = idx_q[ADDR_WIDTH-1:0];
                    wdata_d = {hi_q, bus.rx_data};
                    idx_d   = idx_inc;
`ifdef IMEM_LOADER_CSUM_EN
                    sum_d   = sum_nxt;
`endif
                    if (idx_inc == cnt_q) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state_d = S_CSUM;
`else
                        // Release lands with the last strobe; the CPU leaves reset one edge later.
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
`endif
                    end else begin
                        state_d = S_HI;
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                S_CSUM: begin
                    if (sum_nxt == 8'h00) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule
